// File: rtl/pkg_seq_gen.sv
// Shared types for the serial "101" stimulus generator and its match tracker.
package pkg_seq_gen;

  typedef enum logic {G_IDLE, G_SHIFT} gen_state_t;

  typedef enum logic [1:0] {T0, T1, T2} trk_state_t;

  // Bit pattern the downstream detector looks for, oldest bit first.
  localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/seq_match_tracker.sv
// Golden Mealy "101" overlapping detector; match is valid in the cycle of the completing bit.
module seq_match_tracker
  import pkg_seq_gen::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  output logic match
);

  trk_state_t trk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk <= T0;
    end else begin
      case (trk)
        T0:      trk <= bit_in ? T1 : T0;
        T1:      trk <= bit_in ? T1 : T2;
        T2:      trk <= bit_in ? T1 : T0;
        default: trk <= T0;
      endcase
    end
  end

  assign match = (trk == T2) && bit_in;

endmodule

// File: rtl/seq_gen_tx.sv
// MSB-first serializer feeding the "101" detector, with a cycle-aligned expected-match output.
// Optional SEQ_GEN_MATCH_CNT_EN adds a saturating match_cnt output.
module seq_gen_tx
  import pkg_seq_gen::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             seq,
  output logic             seq_valid,
  output logic             busy,
  output logic             exp_match
`ifdef SEQ_GEN_MATCH_CNT_EN
  ,
  output logic [15:0]      match_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  gen_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bitcnt;
  logic             last_bit;
  logic             xfer;

  assign last_bit = (bitcnt == '0);
  // Ready in idle, or on the last bit so the next word follows with no gap.
  assign in_ready = rst_n && ((state == G_IDLE) || last_bit);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= G_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        G_IDLE: begin
          if (xfer) begin
            state  <= G_SHIFT;
            shreg  <= in_data;
            bitcnt <= CNT_W'(WIDTH - 1);
          end
        end
        G_SHIFT: begin
          if (last_bit) begin
            if (xfer) begin
              shreg  <= in_data;
              bitcnt <= CNT_W'(WIDTH - 1);
            end else begin
              state <= G_IDLE;
              shreg <= '0;
            end
          end else begin
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            bitcnt <= bitcnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= G_IDLE;
          shreg  <= '0;
          bitcnt <= '0;
        end
      endcase
    end
  end

  assign seq       = (state == G_SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;
  assign seq_valid = (state == G_SHIFT);
  assign busy      = (state == G_SHIFT);

  // Tracker sees every bit on the line, idle bits included.
  seq_match_tracker u_trk (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (seq),
    .match  (exp_match)
  );

`ifdef SEQ_GEN_MATCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (exp_match && (match_cnt != 16'hFFFF)) begin
      match_cnt <= match_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed self-checking bench for seq_gen_tx (define SEQ_GEN_MATCH_CNT_EN to cover match_cnt).
module tb_seq_gen_tx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       seq;
  logic       seq_valid;
  logic       busy;
  logic       exp_match;
`ifdef SEQ_GEN_MATCH_CNT_EN
  logic [15:0] match_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_gen_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .seq       (seq),
    .seq_valid (seq_valid),
    .busy      (busy),
    .exp_match (exp_match)
`ifdef SEQ_GEN_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_m);
    chk({tag, "_seq"},   16'(seq),       16'(1'b0));
    chk({tag, "_valid"}, 16'(seq_valid), 16'(1'b0));
    chk({tag, "_busy"},  16'(busy),      16'(1'b0));
    chk({tag, "_ready"}, 16'(in_ready),  16'(1'b1));
    chk({tag, "_match"}, 16'(exp_match), 16'(exp_m));
  endtask

  // Checks the 8 bit-cycles of word w; at bit nv_at drives in_valid/in_data to nv/nd.
  task automatic chk_word(input string tag, input logic [7:0] w, input logic [7:0] mmask,
                          input logic [7:0] rmask, input int nv_at, input logic nv,
                          input logic [7:0] nd);
    for (int i = 0; i < 8; i++) begin
      if (i == nv_at) begin
        in_valid = nv;
        in_data  = nd;
      end
      chk($sformatf("%s_seq%0d", tag, i),   16'(seq),       16'(w[7-i]));
      chk($sformatf("%s_valid%0d", tag, i), 16'(seq_valid), 16'(1'b1));
      chk($sformatf("%s_busy%0d", tag, i),  16'(busy),      16'(1'b1));
      chk($sformatf("%s_match%0d", tag, i), 16'(exp_match), 16'(mmask[i]));
      chk($sformatf("%s_ready%0d", tag, i), 16'(in_ready),  16'(rmask[i]));
      tick();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    chk("rst_seq",   16'(seq),       16'(1'b0));
    chk("rst_valid", 16'(seq_valid), 16'(1'b0));
    chk("rst_busy",  16'(busy),      16'(1'b0));
    chk("rst_ready", 16'(in_ready),  16'(1'b0));
    chk("rst_match", 16'(exp_match), 16'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("post_rst", 1'b0);

    // A5: matches at bits 2 and 7, then idle.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    chk_word("a5", 8'hA5, 8'b1000_0100, 8'b1000_0000, 0, 1'b0, 8'h00);
    chk_idle("a5_end", 1'b0);
    tick(); tick(); tick();

    // 81 then 40 back-to-back: only match is across the word boundary.
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick();
    chk_word("w81", 8'h81, 8'b0000_0000, 8'b1000_0000, 7, 1'b1, 8'h40);
    chk_word("w40", 8'h40, 8'b0000_0010, 8'b1000_0000, 0, 1'b0, 8'h00);
    chk_idle("w40_end", 1'b0);
    tick(); tick(); tick();

    // 01, one idle zero, 80: match on the 80 MSB.
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    chk_word("w01", 8'h01, 8'b0000_0000, 8'b1000_0000, 0, 1'b0, 8'h00);
    chk_idle("gap", 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h80;
    tick();
    chk_word("w80", 8'h80, 8'b0000_0001, 8'b1000_0000, 0, 1'b0, 8'h00);
    chk_idle("w80_end", 1'b0);
    tick(); tick(); tick();

    // FF offered at bit 3 of 00; accepted only on bit 7.
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    chk_word("w00", 8'h00, 8'b0000_0000, 8'b1000_0000, 3, 1'b1, 8'hFF);
    chk_word("wff", 8'hFF, 8'b0000_0000, 8'b1000_0000, 0, 1'b0, 8'h00);
    chk_idle("wff_end", 1'b0);
    tick(); tick(); tick();

    // Reset after 3 bits of A5.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_seq2",   16'(seq),       16'(1'b1));
    chk("mid_match2", 16'(exp_match), 16'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seq",   16'(seq),       16'(1'b0));
    chk("mid_rst_valid", 16'(seq_valid), 16'(1'b0));
    chk("mid_rst_busy",  16'(busy),      16'(1'b0));
    chk("mid_rst_match", 16'(exp_match), 16'(1'b0));
    chk("mid_rst_ready", 16'(in_ready),  16'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_idle($sformatf("after_rst%0d", i), 1'b0);
      tick();
    end

`ifdef SEQ_GEN_MATCH_CNT_EN
    // AA AA back-to-back: seven overlapping matches.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("cnt_rst", match_cnt, 16'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    chk_word("aa0", 8'hAA, 8'b0101_0100, 8'b1000_0000, 0, 1'b1, 8'hAA);
    chk_word("aa1", 8'hAA, 8'b0101_0101, 8'b1000_0000, 0, 1'b0, 8'h00);
    chk("cnt_final", match_cnt, 16'd7);
    chk_idle("aa_end", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen_tx.md
Name: seq_gen_tx

Overview:
- Serial bit-stream transmitter that drives the single-bit `seq` line consumed by the team's Mealy "101" overlapping sequence detectors.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first, back-to-back with no gap.
- Produces `exp_match`, a reference-model pulse aligned with the detector's Mealy output, so benches compare the detector against it cycle by cycle.

Parameters:
- WIDTH, 8: payload word width in bits (≥2).
- IDLE_BIT, 1'b0: value driven on `seq` when no word is being shifted.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to serialize, MSB transmitted first.
- seq  out  1  serial bit line to detector.
- seq_valid  out  1  seq carries a payload bit this cycle.
- busy  out  1  a word is in flight (state G_SHIFT).
- exp_match  out  1  expected detector output this cycle (Mealy-aligned).

Behaviour:
- Reset (rst_n low, async):
  - state G_IDLE; seq=IDLE_BIT; seq_valid=0; busy=0.
  - Shift register and bit counter cleared; tracker at T0.
  - in_ready forced 0 while rst_n is low; exp_match=0.
- FSM states:
  - G_IDLE: seq=IDLE_BIT, seq_valid=0, in_ready=1.
  - G_SHIFT: seq=shreg[WIDTH-1], seq_valid=1.
- Handshake: transfer occurs on a clock edge with in_valid && in_ready. in_data is sampled at that edge.
- G_IDLE + transfer → G_SHIFT.
  - Load shreg=in_data and bitcnt=WIDTH-1.
  - First bit appears on seq in the cycle after the transfer edge (latency 1).
- G_SHIFT:
  - Each edge: shreg shifts left by 1 and bitcnt decrements.
  - in_ready=1 only when bitcnt==0 (last bit).
  - Last bit + transfer: reload shreg and bitcnt; stay in G_SHIFT. The next word's MSB follows with zero idle cycles.
  - Last bit, no transfer → G_IDLE.
- in_valid asserted while in_ready=0: ignored; producer must hold data.
- Tracker (mirrors the detector) advances on every edge using the current seq value, including idle bits:
  - T0: 1→T1, 0→T0.
  - T1: 0→T2, 1→T1.
  - T2: 1→T1, 0→T0.
- exp_match = (trk==T2) && (seq==1), combinational from registers. It is therefore valid in the same cycle as the completing bit, and overlap is allowed.
- Reset mid-word: word is discarded, no residual bits after release, and the tracker restarts at T0.
- bitcnt width is $clog2(WIDTH); it never wraps, since reload or exit occurs at 0.

Optional Feature:
- Macro: SEQ_GEN_MATCH_CNT_EN.
- When defined:
  - Adds output `match_cnt[15:0]`, which increments on every cycle with exp_match=1.
  - It saturates at 16'hFFFF and is cleared by rst_n.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- New package pkg_seq_gen, holding:
  - typedef enum gen_state_t {G_IDLE, G_SHIFT};
  - typedef enum trk_state_t {T0, T1, T2};
  - localparam PATTERN=3'b101 for documentation and bench use.
- One sub-module, seq_match_tracker:
  - Inputs: clk, rst_n, bit_in. Output: match.
  - Contains the tracker FSM and is reusable by benches as a golden model.

Test Plan:
- Reset, send 8'hA5 → seq=1,0,1,0,0,1,0,1 on 8 consecutive cycles with seq_valid=1; exp_match high at bit indices 2 and 7 only; then seq=0, seq_valid=0, busy=0.
- Send 8'h81 and 8'h40 back-to-back (in_valid held) → 16 contiguous valid bits, in_ready high only on bit 7; a single exp_match at bit 1 of the second word (cross-boundary overlap).
- Send 8'h01, deassert in_valid one cycle, then send 8'h80 → exactly one idle 0 between words; exp_match at the 8'h80 MSB.
- in_valid=1 with 8'hFF during bit 3 of 8'h00 → in_ready=0, no transfer; 8'hFF is accepted only on bit 7 and follows immediately.
- Assert rst_n low after 3 bits of 8'hA5 → seq=0, seq_valid=0, exp_match=0, in_ready=0 immediately; after release in_ready=1 and no leftover bits appear.
- With SEQ_GEN_MATCH_CNT_EN, send 8'hAA, 8'hAA back-to-back → exactly 7 exp_match pulses; match_cnt=7 after the final bit.
